// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared types for the VGA frame-buffer write/read paths.
// Also provides default VGA mode macros when the build does not set them.
`ifndef VGA_MODE_H_VISIBLE
`define VGA_MODE_H_VISIBLE 640
`endif
`ifndef VGA_MODE_V_VISIBLE
`define VGA_MODE_V_VISIBLE 480
`endif

package vga_fb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SEND = 2'd2
   } wr_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/vga_fb_addr_calc.sv
// vga_fb_addr_calc: registered row*H_VISIBLE + col linear address.
// The product wraps modulo 2^ADDR_W; shared with the pixel streamer.
module vga_fb_addr_calc #(
   parameter int H_VISIBLE = 640,
   parameter int X_BITS    = 10,
   parameter int Y_BITS    = 9,
   parameter int ADDR_W    = 20
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic [X_BITS-1:0] col_i,
   input  logic [Y_BITS-1:0] row_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] addr_q;

   // Multiply-add truncated to the address width.
   always_comb begin
      addr_d = ADDR_W'(row_i) * ADDR_W'(H_VISIBLE) + ADDR_W'(col_i);
   end

   // Capture the address when a new coordinate is presented.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
      end else if (en_i) begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/vga_fb_pixel_writer.sv
// vga_fb_pixel_writer: single-pixel writes to the frame buffer via AXI.
// Optional clipping of off-screen requests: VGA_FB_PIXEL_WRITER_CLIP_EN.
module vga_fb_pixel_writer
   import vga_fb_pkg::*;
#(
   parameter int PIXEL_BITS      = 12,
   parameter int META_BITS       = 4,
   parameter int H_VISIBLE       = `VGA_MODE_H_VISIBLE,
   parameter int V_VISIBLE       = `VGA_MODE_V_VISIBLE,
   parameter int AXI_ADDR_WIDTH  = 20,
   parameter int AXI_DATA_WIDTH  = 16,
   parameter int MAX_OUTSTANDING = 4,
   localparam int X_BITS         = $clog2(H_VISIBLE),
   localparam int Y_BITS         = $clog2(V_VISIBLE)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [X_BITS-1:0]           wr_x,
   input  logic [Y_BITS-1:0]           wr_y,
   input  logic [PIXEL_BITS-1:0]       wr_color,
   input  logic [META_BITS-1:0]        wr_meta,
   output logic [AXI_ADDR_WIDTH-1:0]   sram_axi_awaddr,
   output logic                        sram_axi_awvalid,
   input  logic                        sram_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]   sram_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] sram_axi_wstrb,
   output logic                        sram_axi_wvalid,
   input  logic                        sram_axi_wready,
   input  logic [1:0]                  sram_axi_bresp,
   input  logic                        sram_axi_bvalid,
   output logic                        sram_axi_bready,
   output logic                        dropped,
   output logic                        err,
   output logic                        idle
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   wr_state_e                 state_q;
   logic                      wr_ready_q;
   logic                      awvalid_q;
   logic                      wvalid_q;
   logic                      err_q;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [CNT_W-1:0]          cnt_d;
   logic [AXI_ADDR_WIDTH-1:0] calc_addr;

   logic accept;
   logic clip_hit;
   logic take;
   logic aw_done;
   logic w_done;
   logic send_done;
   logic b_fire;
   logic b_bad;
   logic ready_d;

`ifdef VGA_FB_PIXEL_WRITER_CLIP_EN
   logic dropped_q;
   assign clip_hit = (int'(wr_x) >= H_VISIBLE) ||
                     (int'(wr_y) >= V_VISIBLE);
   assign dropped  = dropped_q;
`else
   assign clip_hit = 1'b0;
   assign dropped  = 1'b0;
`endif

   // Handshake decode and outstanding-write bookkeeping.
   always_comb begin
      accept    = (state_q == IDLE) && wr_valid && wr_ready_q;
      take      = accept && !clip_hit;
      aw_done   = !awvalid_q || sram_axi_awready;
      w_done    = !wvalid_q || sram_axi_wready;
      send_done = (state_q == SEND) && aw_done && w_done;
      b_fire    = sram_axi_bvalid;
      b_bad     = b_fire &&
                  ((sram_axi_bresp != RESP_OKAY) || (cnt_q == '0));
      cnt_d     = cnt_q
                + CNT_W'(send_done)
                - CNT_W'(b_fire && (cnt_q != '0));
      ready_d   = (cnt_d < MAX_CNT);
   end

   vga_fb_addr_calc #(
      .H_VISIBLE (H_VISIBLE),
      .X_BITS    (X_BITS),
      .Y_BITS    (Y_BITS),
      .ADDR_W    (AXI_ADDR_WIDTH)
   ) u_addr_calc (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (take),
      .col_i  (wr_x),
      .row_i  (wr_y),
      .addr_o (calc_addr)
   );

   // Pixel-write FSM with registered AXI outputs and response tracking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         wr_ready_q <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
`ifdef VGA_FB_PIXEL_WRITER_CLIP_EN
         dropped_q  <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_d;
         if (b_bad) begin
            err_q <= 1'b1;
         end
`ifdef VGA_FB_PIXEL_WRITER_CLIP_EN
         dropped_q <= accept && clip_hit;
`endif
         unique case (state_q)
            IDLE: begin
               if (take) begin
                  wdata_q    <= AXI_DATA_WIDTH'({wr_color, wr_meta});
                  wr_ready_q <= 1'b0;
                  state_q    <= CALC;
               end else begin
                  wr_ready_q <= ready_d;
               end
            end
            CALC: begin
               awaddr_q   <= calc_addr;
               awvalid_q  <= 1'b1;
               wvalid_q   <= 1'b1;
               wr_ready_q <= 1'b0;
               state_q    <= SEND;
            end
            SEND: begin
               if (awvalid_q && sram_axi_awready) begin
                  awvalid_q <= 1'b0;
               end
               if (wvalid_q && sram_axi_wready) begin
                  wvalid_q <= 1'b0;
               end
               if (send_done) begin
                  wr_ready_q <= ready_d;
                  state_q    <= IDLE;
               end
            end
            default: begin
               wr_ready_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign wr_ready         = wr_ready_q;
   assign sram_axi_awaddr  = awaddr_q;
   assign sram_axi_awvalid = awvalid_q;
   assign sram_axi_wdata   = wdata_q;
   assign sram_axi_wstrb   = '1;
   assign sram_axi_wvalid  = wvalid_q;
   assign sram_axi_bready  = 1'b1;
   assign err              = err_q;
   assign idle             = (state_q == IDLE) && (cnt_q == '0);

endmodule

// File: tb/tb_vga_fb_pixel_writer.sv
// tb_vga_fb_pixel_writer: directed vectors and corner-case sequences
// for the frame-buffer pixel writer (640x480 default mode).
module tb_vga_fb_pixel_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [9:0]  wr_x;
   logic [8:0]  wr_y;
   logic [11:0] wr_color;
   logic [3:0]  wr_meta;
   logic [19:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [15:0] wdata;
   logic [1:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic        dropped;
   logic        err;
   logic        idle;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_fb_pixel_writer dut (
      .clk              (clk),
      .reset            (reset),
      .wr_valid         (wr_valid),
      .wr_ready         (wr_ready),
      .wr_x             (wr_x),
      .wr_y             (wr_y),
      .wr_color         (wr_color),
      .wr_meta          (wr_meta),
      .sram_axi_awaddr  (awaddr),
      .sram_axi_awvalid (awvalid),
      .sram_axi_awready (awready),
      .sram_axi_wdata   (wdata),
      .sram_axi_wstrb   (wstrb),
      .sram_axi_wvalid  (wvalid),
      .sram_axi_wready  (wready),
      .sram_axi_bresp   (bresp),
      .sram_axi_bvalid  (bvalid),
      .sram_axi_bready  (bready),
      .dropped          (dropped),
      .err              (err),
      .idle             (idle)
   );

   typedef struct {
      logic [9:0]  x;
      logic [8:0]  y;
      logic [11:0] c;
      logic [3:0]  m;
      logic [19:0] addr;
      logic [15:0] data;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   // Pulse one B response across a single rising edge.
   task automatic b_pulse(input logic [1:0] resp);
      bvalid = 1'b1;
      bresp  = resp;
      @(negedge clk);
      bvalid = 1'b0;
      bresp  = 2'b00;
   endtask

   // Issue one pixel and capture the address/data seen at handshake.
   task automatic send_px(input logic [9:0] x, input logic [8:0] y,
                          input logic [11:0] c, input logic [3:0] m,
                          output logic [19:0] a, output logic [15:0] d,
                          output bit ok);
      bit ga;
      bit gw;
      int n;
      ga = 0;
      gw = 0;
      a  = '0;
      d  = '0;
      ok = 0;
      n  = 0;
      while (!wr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) begin
         timeout("wr_ready wait");
         return;
      end
      wr_x     = x;
      wr_y     = y;
      wr_color = c;
      wr_meta  = m;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (awvalid && awready && !ga) begin
            a  = awaddr;
            ga = 1;
         end
         if (wvalid && wready && !gw) begin
            d  = wdata;
            gw = 1;
         end
         @(negedge clk);
         if (ga && gw) break;
      end
      ok = ga && gw;
      if (!ok) timeout("aw/w handshake");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [19:0] a;
      logic [15:0] d;
      bit          ok;

      vecs[0] = '{10'd0,   9'd0,   12'h123, 4'h4, 20'd0,      16'h1234};
      vecs[1] = '{10'd639, 9'd0,   12'hFFF, 4'hF, 20'd639,    16'hFFFF};
      vecs[2] = '{10'd0,   9'd1,   12'h800, 4'h1, 20'd640,    16'h8001};
      vecs[3] = '{10'd639, 9'd479, 12'h5A5, 4'hA, 20'd307199, 16'h5A5A};
      vecs[4] = '{10'd100, 9'd200, 12'h0F0, 4'h7, 20'd128100, 16'h0F07};
      vecs[5] = '{10'd17,  9'd33,  12'hC3C, 4'hE, 20'd21137,  16'hC3CE};

      reset    = 1'b0;
      wr_valid = 1'b0;
      wr_x     = '0;
      wr_y     = '0;
      wr_color = '0;
      wr_meta  = '0;
      awready  = 1'b1;
      wready   = 1'b1;
      bresp    = 2'b00;
      bvalid   = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst wr_ready", 32'(wr_ready), 32'd0);
      chk("rst awvalid", 32'(awvalid), 32'd0);
      chk("rst wvalid", 32'(wvalid), 32'd0);
      chk("rst bready", 32'(bready), 32'd1);
      chk("rst awaddr", 32'(awaddr), 32'd0);
      chk("rst wdata", 32'(wdata), 32'd0);
      chk("rst dropped", 32'(dropped), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst idle", 32'(idle), 32'd1);
      reset = 1'b1;
      chk("release wr_ready pre-edge", 32'(wr_ready), 32'd0);
      @(negedge clk);
      chk("release wr_ready post-edge", 32'(wr_ready), 32'd1);

      // Single write with exact cycle timing
      wr_x     = 10'd5;
      wr_y     = 9'd2;
      wr_color = 12'hABC;
      wr_meta  = 4'h3;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("t1 N wr_ready", 32'(wr_ready), 32'd0);
      chk("t1 N awvalid", 32'(awvalid), 32'd0);
      @(negedge clk);
      chk("t1 N+1 awvalid", 32'(awvalid), 32'd1);
      chk("t1 N+1 wvalid", 32'(wvalid), 32'd1);
      chk("t1 awaddr", 32'(awaddr), 32'd1285);
      chk("t1 wdata", 32'(wdata), 32'hABC3);
      chk("t1 wstrb", 32'(wstrb), 32'd3);
      chk("t1 N+1 wr_ready", 32'(wr_ready), 32'd0);
      @(negedge clk);
      chk("t1 N+2 awvalid", 32'(awvalid), 32'd0);
      chk("t1 N+2 wvalid", 32'(wvalid), 32'd0);
      chk("t1 N+2 wr_ready", 32'(wr_ready), 32'd1);
      chk("t1 idle pending B", 32'(idle), 32'd0);
      b_pulse(2'b00);
      chk("t1 idle after B", 32'(idle), 32'd1);

      // Address/data vector table
      for (int i = 0; i < 6; i++) begin
         send_px(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].m, a, d, ok);
         if (ok) begin
            chk($sformatf("vec%0d awaddr", i), 32'(a), 32'(vecs[i].addr));
            chk($sformatf("vec%0d wdata", i), 32'(d), 32'(vecs[i].data));
         end
         b_pulse(2'b00);
         chk($sformatf("vec%0d idle", i), 32'(idle), 32'd1);
      end

      // AW ready delayed, W ready immediately
      awready  = 1'b0;
      wr_x     = 10'd9;
      wr_y     = 9'd3;
      wr_color = 12'h111;
      wr_meta  = 4'h2;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      chk("awdly awvalid", 32'(awvalid), 32'd1);
      chk("awdly wvalid", 32'(wvalid), 32'd1);
      chk("awdly awaddr", 32'(awaddr), 32'd1929);
      @(negedge clk);
      chk("awdly wvalid dropped", 32'(wvalid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("awdly awvalid held", 32'(awvalid), 32'd1);
         chk("awdly awaddr stable", 32'(awaddr), 32'd1929);
         chk("awdly wr_ready low", 32'(wr_ready), 32'd0);
         @(negedge clk);
      end
      awready = 1'b1;
      @(negedge clk);
      chk("awdly awvalid done", 32'(awvalid), 32'd0);
      chk("awdly wr_ready back", 32'(wr_ready), 32'd1);
      chk("awdly idle pending", 32'(idle), 32'd0);
      b_pulse(2'b00);
      chk("awdly single count", 32'(idle), 32'd1);

      // B withheld: outstanding limit
      for (int i = 0; i < 4; i++) begin
         send_px(10'(i), 9'd0, 12'h222, 4'h1, a, d, ok);
      end
      chk("full wr_ready", 32'(wr_ready), 32'd0);
      wr_x     = 10'd3;
      wr_y     = 9'd4;
      wr_color = 12'h333;
      wr_meta  = 4'h3;
      wr_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("full no accept", 32'(awvalid), 32'd0);
      chk("full wr_ready held", 32'(wr_ready), 32'd0);
      b_pulse(2'b00);
      chk("slot freed wr_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      wr_valid = 1'b0;
      chk("5th accepted", 32'(wr_ready), 32'd0);
      @(negedge clk);
      chk("5th awvalid", 32'(awvalid), 32'd1);
      chk("5th awaddr", 32'(awaddr), 32'd2563);
      @(negedge clk);
      chk("5th awvalid done", 32'(awvalid), 32'd0);
      for (int i = 0; i < 4; i++) b_pulse(2'b00);
      chk("drain idle", 32'(idle), 32'd1);

      // Error response on second of three writes
      send_px(10'd1, 9'd1, 12'h444, 4'h4, a, d, ok);
      b_pulse(2'b00);
      chk("bresp ok err", 32'(err), 32'd0);
      send_px(10'd2, 9'd1, 12'h555, 4'h5, a, d, ok);
      b_pulse(2'b10);
      chk("bresp slverr err", 32'(err), 32'd1);
      send_px(10'd3, 9'd1, 12'h666, 4'h6, a, d, ok);
      if (ok) chk("third write awaddr", 32'(a), 32'd643);
      b_pulse(2'b00);
      chk("err sticky", 32'(err), 32'd1);
      chk("err idle", 32'(idle), 32'd1);

`ifdef VGA_FB_PIXEL_WRITER_CLIP_EN
      // Off-screen request is clipped
      wr_x     = 10'd640;
      wr_y     = 9'd0;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("clip dropped", 32'(dropped), 32'd1);
      chk("clip awvalid", 32'(awvalid), 32'd0);
      chk("clip wvalid", 32'(wvalid), 32'd0);
      chk("clip wr_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      chk("clip dropped pulse", 32'(dropped), 32'd0);
      chk("clip awvalid after", 32'(awvalid), 32'd0);
      chk("clip idle", 32'(idle), 32'd1);
`else
      // Off-screen request wraps into the address space
      send_px(10'd640, 9'd0, 12'h777, 4'h7, a, d, ok);
      if (ok) chk("noclip awaddr", 32'(a), 32'd640);
      chk("noclip dropped", 32'(dropped), 32'd0);
      b_pulse(2'b00);
`endif

      // Reset asserted during SEND
      awready  = 1'b0;
      wready   = 1'b0;
      wr_x     = 10'd7;
      wr_y     = 9'd1;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      chk("pre-reset awvalid", 32'(awvalid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async awvalid", 32'(awvalid), 32'd0);
      chk("async wvalid", 32'(wvalid), 32'd0);
      chk("async err cleared", 32'(err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      chk("rerelease idle", 32'(idle), 32'd1);
      chk("rerelease wr_ready", 32'(wr_ready), 32'd0);
      @(negedge clk);
      chk("rerelease wr_ready edge", 32'(wr_ready), 32'd1);
      awready = 1'b1;
      wready  = 1'b1;

      // Stray B response with nothing outstanding
      b_pulse(2'b00);
      chk("stray B err", 32'(err), 32'd1);
      chk("stray B idle", 32'(idle), 32'd1);
      send_px(10'd2, 9'd2, 12'h999, 4'h9, a, d, ok);
      if (ok) chk("post-stray awaddr", 32'(a), 32'd1282);
      b_pulse(2'b00);
      chk("counter saturated", 32'(idle), 32'd1);
      chk("post-stray wr_ready", 32'(wr_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
